rsa_byte_stream: RTL and testbench
==================================

# rsa_byte_stream

Byte-stream front/back end for the modular exponentiation core. Accepts plaintext as an 8-bit valid/ready stream, packs K/8 bytes into one K-bit operand, drives the exponentiator's start/done handshake with that operand as base and a key as exponent, captures the K-bit result and streams it back out as K/8 bytes. The block sits directly around the exponentiator: its `exp_*` ports connect one-to-one to the core's operand, start, result and done pins.

## Interface
- `K`, 192: operand width in bits; multiple of 8.
- `NB`, K/8: bytes per word (derived, not overridden).
- `M`, 192'hfffffffffffffffffffffffffffffffeffffffffffffffff: modulus; used only by the range check.
- `clk  in  1`: clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `in_valid  in  1`: input byte valid.
- `in_ready  out  1`: block accepts a byte this cycle.
- `in_data  in  8`: input byte; first byte of a word is the most significant.
- `key  in  K`: exponent; sampled on the cycle the last byte of a word is accepted.
- `out_valid  out  1`: output byte valid.
- `out_ready  in  1`: downstream accepts output byte.
- `out_data  out  8`: output byte, most significant first.
- `out_last  out  1`: marks byte NB-1 of a result word.
- `out_err  out  1`: word rejected by range check (see Configuration).
- `exp_start  out  1`: start level to exponentiator.
- `exp_x  out  K`: exponent operand (registered key).
- `exp_y  out  K`: base operand (packed word).
- `exp_z  in  K`: exponentiator result.
- `exp_done  in  1`: exponentiator done level; held high while `exp_start` is high.
- `busy  out  1`: state is not COLLECT.

## Operation
- States: COLLECT, LAUNCH, RELEASE, EMIT.
- COLLECT: `in_ready`=1. Each `in_valid&&in_ready` shifts `y <= {y[K-9:0], in_data}`, byte count +1. On accepting byte NB-1: `exp_x <= key`, count cleared, go LAUNCH.
- LAUNCH: `exp_start`=1; `exp_x`/`exp_y` held constant. When `exp_done`=1: `res <= exp_z`, go RELEASE.
- RELEASE: `exp_start`=0; stay until `exp_done`=0, then go EMIT. Guarantees the core is back in idle before any relaunch.
- EMIT: `out_valid`=1, `out_data`=`res[K-1:K-8]`. On `out_valid&&out_ready`: `res <= res<<8`, count +1. `out_last`=1 when count==NB-1; handshake on that byte returns to COLLECT.
- `out_data` and `out_last` stable while `out_valid && !out_ready`.
- `in_valid` outside COLLECT is ignored (not consumed). `exp_done` outside LAUNCH/RELEASE is ignored.
- Changes on `key` after sampling have no effect on the word in flight.

## Timing
- Reset values: state COLLECT, `in_ready`=1, `out_valid`=0, `out_last`=0, `out_err`=0, `exp_start`=0, `exp_x`=0, `exp_y`=0, `busy`=0, counters 0.
- All outputs are decodes of registered state or registered data; no input-to-output combinational path.
- Last byte accepted at edge T -> `exp_start`=1 from T+1.
- `exp_done` seen high at edge D -> `exp_start`=0 from D+1; EMIT entered one edge after `exp_done` is seen low; first `out_valid` that cycle.
- Emission with `out_ready` held 1: NB cycles; `in_ready`=1 the cycle after the last output handshake.
- Reset mid-operation: returns to COLLECT immediately, partial word and result discarded, `exp_start` drops asynchronously.

## Configuration
- Macro `RSA_BSTREAM_RANGE_CHK_EN`.
- Defined: on accepting byte NB-1, if the packed word (comparing the full K-bit value including that byte) is `>= M`, LAUNCH/RELEASE are skipped; go directly to EMIT with `res`=0 and `out_err`=1 for all NB bytes of that word; `out_err` clears on return to COLLECT.
- Undefined: no comparator; every word is launched; `out_err` constant 0.

## Test plan
- Bench core model; bytes 0x00×23,0x02, key=3 -> `exp_start` rises one cycle after last byte; output 0x00×23,0x08, `out_last` only on 0x08.
- Output backpressure: `out_ready` toggled 1/0 every cycle -> bytes unchanged while stalled, NB handshakes total, no byte lost or duplicated.
- `in_valid` held high through LAUNCH/RELEASE/EMIT with a second word pending -> `in_ready`=0 there; second word's first byte accepted only after first word's `out_last` handshake.
- Core model holds `exp_done` high 3 cycles after `exp_start` falls -> block stays in RELEASE, `out_valid` rises one cycle after `exp_done` falls.
- Reset asserted after 10 input bytes -> all outputs at reset values; next 24 bytes form a clean word (result matches model).
- With macro: 24×0xFF -> no `exp_start` pulse, output 24×0x00 with `out_err`=1; without macro: same input launches and `out_err`=0.

Source files
------------

// File: rtl/rsa_byte_stream.sv
// Packs the 8-bit input stream into K-bit words, runs each through the modular exponentiator, and streams the result back out as bytes.
// Build macro RSA_BSTREAM_RANGE_CHK_EN rejects words >= M and returns an all-zero result flagged with out_err.
module rsa_byte_stream #(
   parameter int K = 192
`ifdef RSA_BSTREAM_RANGE_CHK_EN
   ,
   parameter logic [K-1:0] M = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff
`endif
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic [K-1:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         out_last,
   output logic         out_err,
   output logic         exp_start,
   output logic [K-1:0] exp_x,
   output logic [K-1:0] exp_y,
   input  logic [K-1:0] exp_z,
   input  logic         exp_done,
   output logic         busy
);

   localparam int NB = K / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

   typedef enum logic [1:0] {COLLECT, LAUNCH, RELEASE, EMIT} state_t;

   state_t        state_q, state_d;
   logic [K-1:0]  y_q, y_d;
   logic [K-1:0]  x_q, x_d;
   logic [K-1:0]  res_q, res_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [K-1:0]  word_next;
   logic          word_bad;

   assign word_next = {y_q[K-9:0], in_data};

`ifdef RSA_BSTREAM_RANGE_CHK_EN
   assign word_bad = (word_next >= M);
`else
   assign word_bad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      x_d     = x_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         COLLECT: begin
            if (in_valid) begin
               y_d = word_next;
               if (cnt_q == LAST) begin
                  x_d   = key;
                  cnt_d = '0;
                  if (word_bad) begin
                     res_d   = '0;
                     err_d   = 1'b1;
                     state_d = EMIT;
                  end else begin
                     state_d = LAUNCH;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         LAUNCH: begin
            if (exp_done) begin
               res_d   = exp_z;
               state_d = RELEASE;
            end
         end
         // Wait for the core to drop done so it is idle before the next launch.
         RELEASE: begin
            if (!exp_done) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               res_d = res_q << 8;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = COLLECT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         y_q     <= '0;
         x_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         x_q     <= x_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == COLLECT);
   assign busy      = (state_q != COLLECT);
   assign exp_start = (state_q == LAUNCH);
   assign out_valid = (state_q == EMIT);
   assign out_data  = res_q[K-1:K-8];
   assign out_last  = (state_q == EMIT) && (cnt_q == LAST);
   assign out_err   = err_q;
   assign exp_x     = x_q;
   assign exp_y     = y_q;

endmodule

// File: tb/tb_rsa_byte_stream.sv
// Table-driven bench for rsa_byte_stream with a behavioural exponentiator stub; directed sequences cover pending input and resets.
// Expectations follow RSA_BSTREAM_RANGE_CHK_EN when the bench is built with that macro.
module tb_rsa_byte_stream;

   localparam int K  = 192;
   localparam int NB = K / 8;
   localparam logic [K-1:0] MOD = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic [K-1:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic         out_last;
   logic         out_err;
   logic         exp_start;
   logic [K-1:0] exp_x;
   logic [K-1:0] exp_y;
   logic [K-1:0] exp_z;
   logic         exp_done;
   logic         busy;

   int n_cmp = 0;
   int n_fail = 0;
   int core_lat = 2;
   int core_hold = 0;
   int lat_cnt = 0;
   int hold_cnt = 0;

   typedef struct {
      logic [K-1:0] word;
      logic [K-1:0] k;
      logic [K-1:0] res;
      logic         err;
      logic         toggle;
      int           hold;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   rsa_byte_stream dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .key(key),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_err(out_err),
      .exp_start(exp_start), .exp_x(exp_x), .exp_y(exp_y), .exp_z(exp_z),
      .exp_done(exp_done), .busy(busy)
   );

   function automatic logic [K-1:0] modexp(input logic [K-1:0] b, input logic [K-1:0] e);
      logic [2*K-1:0] r, bb, mw;
      mw = {{K{1'b0}}, MOD};
      r  = 1;
      bb = {{K{1'b0}}, b} % mw;
      for (int i = 0; i < K; i++) begin
         if (e[i]) r = (r * bb) % mw;
         bb = (bb * bb) % mw;
      end
      return r[K-1:0];
   endfunction

   // Exponentiator stub: done rises core_lat negedges into a launch and lingers core_hold cycles after start drops.
   initial begin
      exp_done = 1'b0;
      exp_z    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_done = 1'b0;
            lat_cnt  = 0;
         end else if (exp_start) begin
            hold_cnt = core_hold;
            if (!exp_done) begin
               if (lat_cnt >= core_lat) begin
                  exp_z    = modexp(exp_y, exp_x);
                  exp_done = 1'b1;
                  lat_cnt  = 0;
               end else begin
                  lat_cnt++;
               end
            end
         end else if (exp_done) begin
            if (hold_cnt == 0) exp_done = 1'b0;
            else hold_cnt--;
         end
      end
   end

   task automatic check_word(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic flag_timeout(input string name);
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s: got timeout, want event within bound", name);
   endtask

   task automatic check_reset_values(input string tag);
      check_bit({tag, "_in_ready"}, in_ready, 1'b1);
      check_bit({tag, "_busy"}, busy, 1'b0);
      check_bit({tag, "_out_valid"}, out_valid, 1'b0);
      check_bit({tag, "_out_last"}, out_last, 1'b0);
      check_bit({tag, "_out_err"}, out_err, 1'b0);
      check_bit({tag, "_exp_start"}, exp_start, 1'b0);
      check_word({tag, "_exp_x"}, exp_x, '0);
      check_word({tag, "_exp_y"}, exp_y, '0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 200) flag_timeout("in_ready_wait");
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Sends a word MSB first; optionally leaves in_valid high with the next word's first byte.
   task automatic send_word(input logic [K-1:0] word, input logic [K-1:0] k, input logic err,
                            input logic pending, input logic [7:0] pend_byte);
      key = k;
      for (int i = NB - 1; i > 0; i--) send_byte(word[8*i +: 8]);
      check_bit("exp_start_before_last", exp_start, 1'b0);
      send_byte(word[7:0]);
      if (pending) begin
         in_valid = 1'b1;
         in_data  = pend_byte;
      end
      check_bit("exp_start_after_last", exp_start, !err);
      check_bit("busy_after_last", busy, 1'b1);
      check_bit("in_ready_after_last", in_ready, 1'b0);
      check_word("exp_x_sampled", exp_x, k);
      check_word("exp_y_packed", exp_y, word);
      key = ~k;
   endtask

   task automatic wait_emit(input logic launch, input int hold);
      int n, hi;
      logic saw, prev_done;
      n = 0; hi = 0; saw = 1'b0; prev_done = 1'b0;
      while (!out_valid && n < 200) begin
         check_bit("in_ready_while_busy", in_ready, 1'b0);
         if (exp_start) saw = 1'b1;
         if (!exp_start && exp_done) hi++;
         prev_done = exp_done;
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) flag_timeout("out_valid_wait");
      check_bit("launched", saw, launch);
      if (launch) begin
         // done falls at a negedge, so one extra posedge sample still sees it high
         check_int("done_high_after_start", hi, hold + 1);
         check_bit("done_high_before_emit", prev_done, 1'b1);
         check_bit("done_low_at_emit", exp_done, 1'b0);
      end
   endtask

   task automatic receive_word(input logic toggle, input logic [K-1:0] exp_res, input logic exp_err);
      logic [K-1:0] got;
      int hs, n;
      logic stalled, held_last;
      logic [7:0] held_data;
      got = '0; hs = 0; n = 0; stalled = 1'b0; held_last = 1'b0; held_data = '0;
      while (hs < NB && n < 400) begin
         out_ready = toggle ? ((n % 2) == 1) : 1'b1;
         if (stalled) begin
            check_int("stall_data", int'(out_data), int'(held_data));
            check_bit("stall_last", out_last, held_last);
         end
         stalled = 1'b0;
         if (!out_valid) begin
            flag_timeout("out_valid_dropped");
            break;
         end
         if (out_ready) begin
            got = {got[K-9:0], out_data};
            check_bit("out_last", out_last, hs == NB - 1);
            check_bit("out_err", out_err, exp_err);
            hs++;
         end else begin
            stalled   = 1'b1;
            held_data = out_data;
            held_last = out_last;
         end
         check_bit("in_ready_during_emit", in_ready, 1'b0);
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b0;
      check_int("handshakes", hs, NB);
      check_word("result", got, exp_res);
      check_bit("in_ready_after_emit", in_ready, 1'b1);
      check_bit("out_valid_after_emit", out_valid, 1'b0);
      check_bit("out_err_after_emit", out_err, 1'b0);
   endtask

   task automatic apply_vector(input vec_t v);
      core_hold = v.hold;
      send_word(v.word, v.k, v.err, 1'b0, 8'h00);
      wait_emit(!v.err, v.hold);
      receive_word(v.toggle, v.res, v.err);
   endtask

   initial begin
      // word, key, expected result, expected err, out_ready toggling, done hold cycles
      vecs[0] = '{192'd2, 192'd3, 192'd8, 1'b0, 1'b0, 0};
      vecs[1] = '{192'd3, 192'd4, 192'h51, 1'b0, 1'b1, 0};
      vecs[2] = '{192'h1_0000_0000_0000_0000_0000_0000, 192'd2, 192'h1_0000_0000_0000_0001, 1'b0, 1'b0, 3};
      vecs[3] = '{192'd5, 192'd0, 192'd1, 1'b0, 1'b0, 0};
      vecs[4] = '{MOD - 192'd1, 192'd1, MOD - 192'd1, 1'b0, 1'b1, 0};
`ifdef RSA_BSTREAM_RANGE_CHK_EN
      vecs[5] = '{MOD, 192'd1, 192'd0, 1'b1, 1'b0, 0};
      vecs[6] = '{{K{1'b1}}, 192'd1, 192'd0, 1'b1, 1'b1, 0};
`else
      vecs[5] = '{MOD, 192'd1, 192'd0, 1'b0, 1'b0, 0};
      vecs[6] = '{{K{1'b1}}, 192'd1, 192'h1_0000_0000_0000_0000, 1'b0, 1'b1, 0};
`endif
      vecs[7] = '{192'h0123456789abcdef_fedcba9876543210_00112233445566ff, 192'd1,
                  192'h0123456789abcdef_fedcba9876543210_00112233445566ff, 1'b0, 1'b1, 3};

      rst_n = 1'b1; in_valid = 1'b0; in_data = '0; key = '0; out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_values("por");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) apply_vector(vecs[i]);

      // Second word's first byte waits on in_valid through the whole first transaction.
      core_hold = 3;
      send_word(192'd2, 192'd5, 1'b0, 1'b1, 8'ha5);
      wait_emit(1'b1, 3);
      receive_word(1'b0, 192'h20, 1'b0);
      core_hold = 0;
      send_word({8'ha5, 176'd0, 8'h03}, 192'd1, 1'b0, 1'b0, 8'h00);
      wait_emit(1'b1, 0);
      receive_word(1'b0, {8'ha5, 176'd0, 8'h03}, 1'b0);

      // Reset with a partial word collected.
      key = 192'd7;
      for (int i = 0; i < 10; i++) send_byte(8'h11);
      #2 rst_n = 1'b0;
      #1 check_reset_values("rst_collect");
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      apply_vector(vecs[0]);

      // Reset while the exponentiator is running.
      send_word(192'd2, 192'd3, 1'b0, 1'b0, 8'h00);
      #2 rst_n = 1'b0;
      #1 check_reset_values("rst_launch");
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      apply_vector(vecs[1]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got timeout, want end of test");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
